// File: rtl/counter_sequencer_if.sv
// Command and counter-side signal bundle for counter_sequencer.
// The slave modport is the sequencer's view. The master modport is the environment's view:
// the host plus the functional counter.
interface counter_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic             abort;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_base;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] q_in;
  logic [1:0]       op;
  logic [WIDTH-1:0] d;
  logic             busy;
  logic             done;
  logic             mismatch;

  modport master (
    output start, abort, cmd_dir, cmd_base, cmd_len, q_in,
    input  op, d, busy, done, mismatch
  );

  modport slave (
    input  start, abort, cmd_dir, cmd_base, cmd_len, q_in,
    output op, d, busy, done, mismatch
  );
endinterface

// File: rtl/counter_sequencer.sv
// Load-then-count ramp initiator for a functional counter.
// It loads the base value and then counts up or down for len cycles.
// It compares the counter's q against the expected value on every count cycle and in the final
// check cycle.
module counter_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input logic                clk_i,
  input logic                aclr_i,
  counter_sequencer_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StLoad, StCount, StCheck} state_e;

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpUp   = 2'b01;
  localparam logic [1:0] OpDown = 2'b10;
  localparam logic [1:0] OpHold = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic             dir_q, dir_d;
  logic             mismatch_q, mismatch_d;
  logic             q_ne;

  assign q_ne = (bus_io.q_in != exp_q);

  // State and command registers, cleared asynchronously by aclr.
  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      state_q    <= StIdle;
      base_q     <= '0;
      exp_q      <= '0;
      len_q      <= '0;
      remain_q   <= '0;
      dir_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      len_q      <= len_d;
      remain_q   <= remain_d;
      dir_q      <= dir_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Next-state logic: command capture, ramp tracking and compare.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    len_d      = len_q;
    remain_d   = remain_q;
    dir_d      = dir_q;
    mismatch_d = mismatch_q;
    unique case (state_q)
      StIdle: begin
        // abort has priority over start, so a simultaneous pair is dropped.
        if (bus_io.start && !bus_io.abort) begin
          base_d     = bus_io.cmd_base;
          dir_d      = bus_io.cmd_dir;
          len_d      = bus_io.cmd_len;
          mismatch_d = 1'b0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        exp_d    = base_q;
        remain_d = len_q;
        if (bus_io.abort) begin
          state_d = StIdle;
        end else if (len_q != '0) begin
          state_d = StCount;
        end else begin
          state_d = StCheck;
        end
      end
      StCount: begin
        if (bus_io.abort) begin
          state_d = StIdle;
        end else begin
          if (q_ne) mismatch_d = 1'b1;
          exp_d    = dir_q ? (exp_q - WIDTH'(1)) : (exp_q + WIDTH'(1));
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = StCheck;
        end
      end
      StCheck: begin
        if (!bus_io.abort && q_ne) mismatch_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    bus_io.op   = OpHold;
    bus_io.d    = '0;
    bus_io.busy = 1'b0;
    bus_io.done = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        bus_io.op   = OpLoad;
        bus_io.d    = base_q;
        bus_io.busy = 1'b1;
      end
      StCount: begin
        bus_io.op   = dir_q ? OpDown : OpUp;
        bus_io.busy = 1'b1;
      end
      StCheck: begin
        bus_io.busy = 1'b1;
        bus_io.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_io.mismatch = mismatch_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer, driving a behavioural functional counter.
module tb_counter_sequencer;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] d;
    logic       busy;
    logic       done;
    logic       mm;
  } exp_t;

  logic       clk;
  logic       aclr;
  logic       fault;
  logic [7:0] cnt_q;
  int         n_checks;
  int         n_pass;
  exp_t       sb_q[$];

  counter_sequencer_if #(.WIDTH(8), .LEN_W(8)) sq_if ();

  counter_sequencer #(.WIDTH(8), .LEN_W(8)) u_dut (
    .clk_i  (clk),
    .aclr_i (aclr),
    .bus_io (sq_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Functional counter sharing the sequencer's clock and clear.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cnt_q <= '0;
    end else begin
      case (sq_if.op)
        2'b00:   cnt_q <= sq_if.d;
        2'b01:   cnt_q <= cnt_q + 8'd1;
        2'b10:   cnt_q <= cnt_q - 8'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // fault flips bit 0 of q to corrupt a single compare.
  assign sq_if.q_in = cnt_q ^ {7'd0, fault};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_eq({tag, " op"},   32'(sq_if.op),       32'(e.op));
    check_eq({tag, " d"},    32'(sq_if.d),        32'(e.d));
    check_eq({tag, " busy"}, 32'(sq_if.busy),     32'(e.busy));
    check_eq({tag, " done"}, 32'(sq_if.done),     32'(e.done));
    check_eq({tag, " mm"},   32'(sq_if.mismatch), 32'(e.mm));
  endtask

  // Issue one command from the post-edge point and score every cycle until the first idle cycle.
  // abort_c, restart_c and inject_c name the cycle after acceptance in which they happen.
  // A value of 0 means the event does not occur.
  // inject_c=k corrupts q during COUNT cycle k.
  task automatic run_cmd(input logic [7:0] base, input logic dir, input logic [7:0] len,
                         input int abort_c, input int restart_c, input int inject_c);
    int   last;
    exp_t e;
    logic [7:0] fin;
    last = (abort_c != 0) ? abort_c + 1 : int'(len) + 3;
    for (int c = 1; c <= last; c++) begin
      e = '{op: 2'b11, d: 8'h00, busy: 1'b0, done: 1'b0, mm: 1'b0};
      if (abort_c != 0 && c > abort_c) begin
        e.op = 2'b11;
      end else if (c == 1) begin
        e.op = 2'b00; e.d = base; e.busy = 1'b1;
      end else if (c <= int'(len) + 1) begin
        e.op = dir ? 2'b10 : 2'b01; e.busy = 1'b1;
      end else if (c == int'(len) + 2) begin
        e.busy = 1'b1; e.done = 1'b1;
      end
      e.mm = (inject_c != 0) && (c > inject_c + 1);
      sb_q.push_back(e);
    end
    fin = dir ? (base - len) : (base + len);
    sq_if.start    = 1'b1;
    sq_if.abort    = 1'b0;
    sq_if.cmd_base = base;
    sq_if.cmd_dir  = dir;
    sq_if.cmd_len  = len;
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      sq_if.abort = (c == abort_c);
      sq_if.start = (c == restart_c);
      if (c == restart_c) begin
        sq_if.cmd_base = ~base;
        sq_if.cmd_dir  = ~dir;
        sq_if.cmd_len  = 8'd1;
      end
      fault = (inject_c != 0) && (c == inject_c + 1);
      @(negedge clk);
      e = sb_q.pop_front();
      check_outputs($sformatf("b%02h c%0d", base, c), e);
      if (e.done && abort_c == 0)
        check_eq($sformatf("b%02h final q", base), 32'(sq_if.q_in), 32'(fin));
      @(posedge clk); #1;
    end
    sq_if.abort = 1'b0;
    sq_if.start = 1'b0;
    fault       = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    fault          = 1'b0;
    sq_if.start    = 1'b0;
    sq_if.abort    = 1'b0;
    sq_if.cmd_dir  = 1'b0;
    sq_if.cmd_base = '0;
    sq_if.cmd_len  = '0;
    aclr           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", '{op: 2'b11, d: 8'h00, busy: 1'b0, done: 1'b0, mm: 1'b0});
    aclr = 1'b0;
    @(posedge clk); #1;

    run_cmd(8'h10, 1'b0, 8'd5, 0, 0, 0);    // up ramp
    run_cmd(8'h02, 1'b1, 8'd4, 0, 0, 0);    // down through zero
    run_cmd(8'hA5, 1'b0, 8'd0, 0, 0, 0);    // zero length
    run_cmd(8'h00, 1'b0, 8'd6, 0, 0, 3);    // corrupted q in COUNT cycle 3
    run_cmd(8'h10, 1'b0, 8'd2, 0, 0, 0);    // acceptance clears mismatch
    run_cmd(8'h30, 1'b0, 8'd10, 3, 2, 0);   // start ignored, abort in COUNT cycle 2
    run_cmd(8'hFE, 1'b0, 8'd3, 0, 0, 0);    // up through 0xFF
    run_cmd(8'h80, 1'b1, 8'd255, 0, 0, 0);  // longest command

    // start and abort together in idle must not be accepted.
    sq_if.start = 1'b1;
    sq_if.abort = 1'b1;
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    sq_if.abort = 1'b0;
    @(negedge clk);
    check_outputs("start+abort", '{op: 2'b11, d: 8'h00, busy: 1'b0, done: 1'b0, mm: 1'b0});
    @(posedge clk); #1;

    // aclr during a long command, with mismatch already set.
    sq_if.start    = 1'b1;
    sq_if.cmd_base = 8'h40;
    sq_if.cmd_dir  = 1'b0;
    sq_if.cmd_len  = 8'd200;
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      fault = (c == 4);
      @(posedge clk); #1;
    end
    fault = 1'b0;
    check_eq("pre-clr mm",   32'(sq_if.mismatch), 32'd1);
    check_eq("pre-clr busy", 32'(sq_if.busy),     32'd1);
    #2 aclr = 1'b1;
    #1;
    check_outputs("mid-clr", '{op: 2'b11, d: 8'h00, busy: 1'b0, done: 1'b0, mm: 1'b0});
    @(negedge clk);
    aclr = 1'b0;
    @(posedge clk); #1;
    run_cmd(8'h55, 1'b1, 8'd3, 0, 0, 0);    // clean run after clear

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
